param_serial_demux: RTL and testbench
=====================================

# param_serial_demux

Parametrised serial message demultiplexer, the successor to the fixed 4-port/4-bit MSSD. It decodes framed messages from a single-wire serial input: start bit, port address, word count, payload, optional parity and stop bit. Each payload word is presented in parallel with its destination port. It reports frame completion and classifies errors. It sits between the serial line receiver and the per-port consumers.

## Interface
- PORTS, 4, number of destination ports (2..16); PORT_W = $clog2(PORTS), derived, not overridable
- DATA_W, 4, payload word width in bits (1..16)
- LEN_W, 4, width of the word-count field; frame carries L+1 words, L in 0..2^LEN_W-1
- PARITY_EN, 1, 1 = even-parity bit follows payload; 0 = no parity bit

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- serIn  in  1  serial line, idle high, sampled every rising edge
- out  out  DATA_W  last completed payload word, MSB received first
- validOut  out  1  one-cycle pulse: out holds a new word
- activePort  out  PORT_W  port address of current/last frame
- busy  out  1  high while a frame is in progress (any state but IDLE)
- done  out  1  one-cycle pulse at end of every frame, good or bad
- error  out  1  one-cycle pulse coincident with done when frame is bad
- errCode  out  2  00 none, 01 bad port, 10 parity, 11 framing; valid when error=1, holds until next done

## Operation
- States: IDLE, ADDR, LEN, DATA, PAR, STOP.
- IDLE: serIn=0 sampled → ADDR; serIn=1 stays.
- ADDR: shift PORT_W bits, MSB first; after last bit → LEN, activePort loaded the same edge.
- LEN: shift LEN_W bits into L, MSB first → DATA. Word counter = L, bit counter = DATA_W-1.
- DATA: shift bit into word register. Parity accumulator XORs every data bit.
  - On the last bit of a word, out gets the full word and validOut=1 in the following cycle.
  - Word counter decrements. After word L+1 → PAR if PARITY_EN else STOP.
- PAR: sampled bit must equal XOR of all payload bits (even parity) → STOP.
- STOP: serIn must be 1. → IDLE always. done pulses next cycle.
- Bad port: address ≥ PORTS, possible only when PORTS is not a power of 2.
  - The frame is still consumed to keep the line in sync.
  - validOut is suppressed for the whole frame; out is not updated.
- Error priority when several apply: framing (11) > parity (10) > bad port (01). Only one error pulse is issued per frame.
- Framing error: stop bit 0. FSM still returns to IDLE, so the 0 is not reinterpreted as a start bit.
- PARITY_EN=0: errCode 10 is never produced.
- Counters are sized from DATA_W and LEN_W. Word count uses LEN_W+1 bits internally so that L=2^LEN_W-1 gives 2^LEN_W words without wrap.

## Timing
- Reset (rst=0): state IDLE, out=0, validOut=0, activePort=0, busy=0, done=0, error=0, errCode=00. Reset takes effect immediately, mid-frame included. Frame is discarded, no done.
- Frame length in cycles: 1 + PORT_W + LEN_W + (L+1)·DATA_W + PARITY_EN + 1.
- validOut rises the cycle after the edge sampling the word's last bit. Exactly one cycle per word; spacing DATA_W cycles.
- done/error/errCode asserted the cycle after the stop-bit edge. busy falls on that same cycle.
- Back-to-back frames: a start bit may be sampled on the edge following the stop bit. done of frame N and the ADDR state of frame N+1 coexist without interaction.
- activePort holds its value from ADDR completion until the next frame's ADDR completion.
- No backpressure: consumers must accept validOut every pulse.

## Test plan
- Defaults, serIn: 0, 11, 0001, 1010, 0110, parity 0, 1. Required: activePort=3; validOut pulses with out=A then out=6 at DATA_W-cycle spacing; done=1, error=0.
- Same frame with parity bit 1. Required: both words output; done with error=1, errCode=10.
- Stop bit 0. Required: error=1, errCode=11; FSM in IDLE next cycle; a following valid frame decodes correctly.
- PORTS=3, address 11, L=0. Required: no validOut, out unchanged; done with errCode=01.
- L=1111, 16 words 0..F. Required: 16 validOut pulses with values in order, then done with no error. Follow with a back-to-back frame and check both frames decode.
- rst pulsed low in the middle of DATA. Required: all outputs are 0 at once; no done; the next frame decodes normally.

Source files
------------

// File: rtl/param_serial_demux_if.sv
// rtl/param_serial_demux_if.sv - serial line and decoded word bundle for param_serial_demux
interface param_serial_demux_if #(
  parameter int PORTS  = 4,
  parameter int DATA_W = 4
) ();
  localparam int PORT_W = $clog2(PORTS);

  logic              serIn;
  logic [DATA_W-1:0] out;
  logic              validOut;
  logic [PORT_W-1:0] activePort;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        errCode;

  // The demux samples the line and drives the decoded results.
  modport master (
    input  serIn,
    output out, validOut, activePort, busy, done, error, errCode
  );

  // A line driver / consumer pair sits on the other side.
  modport slave (
    output serIn,
    input  out, validOut, activePort, busy, done, error, errCode
  );
endinterface

// File: rtl/param_serial_demux.sv
// rtl/param_serial_demux.sv - framed single-wire message demultiplexer with error classification
module param_serial_demux #(
  parameter int PORTS     = 4,
  parameter int DATA_W    = 4,
  parameter int LEN_W     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  param_serial_demux_if.master bus
);
  localparam int PORT_W = $clog2(PORTS);

  // One down-counter serves every field; size it for the widest one.
  localparam int MAX_W  = (DATA_W > LEN_W) ? ((DATA_W > PORT_W) ? DATA_W : PORT_W)
                                           : ((LEN_W > PORT_W) ? LEN_W : PORT_W);
  localparam int CNT_W  = $clog2(MAX_W + 1);

  // Port count widened by one bit so PORTS itself is representable for the range check.
  localparam logic [PORT_W:0] PORTS_L = (PORT_W + 1)'(PORTS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_PAR  = 3'd4;
  localparam logic [2:0] S_STOP = 3'd5;

  logic [2:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  // One extra bit so a full-scale length field never wraps the word count.
  logic [LEN_W:0]    word_cnt;
  logic [PORT_W-1:0] addr_sh;
  logic [LEN_W-1:0]  len_sh;
  logic [DATA_W-1:0] word_sh;
  logic              par_acc;
  logic              par_err;
  logic              bad_port;

  logic [DATA_W-1:0] out_q;
  logic              valid_q;
  logic [PORT_W-1:0] port_q;
  logic              done_q;
  logic              error_q;
  logic [1:0]        code_q;

  logic [PORT_W-1:0] addr_next;
  logic [LEN_W-1:0]  len_next;
  logic [DATA_W-1:0] word_next;
  logic              last_bit;
  logic              last_word;
  logic [1:0]        stop_code;

  // Every field arrives MSB first, so each shift register takes the new bit at the bottom.
  assign addr_next = PORT_W'({addr_sh, bus.serIn});
  assign len_next  = LEN_W'({len_sh, bus.serIn});
  assign word_next = DATA_W'({word_sh, bus.serIn});
  assign last_bit  = (bit_cnt == '0);
  assign last_word = (word_cnt == '0);

  // Error classification at the stop bit: framing beats parity beats bad port.
  always_comb begin
    stop_code = 2'b00;
    if (!bus.serIn) begin
      stop_code = 2'b11;
    end else if (par_err) begin
      stop_code = 2'b10;
    end else if (bad_port) begin
      stop_code = 2'b01;
    end
  end

  // Frame walker: steps through the fields and raises the word and frame pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
      addr_sh  <= '0;
      len_sh   <= '0;
      word_sh  <= '0;
      par_acc  <= 1'b0;
      par_err  <= 1'b0;
      bad_port <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      port_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!bus.serIn) begin
            state   <= S_ADDR;
            bit_cnt <= CNT_W'(PORT_W - 1);
          end
        end
        S_ADDR: begin
          addr_sh <= addr_next;
          if (last_bit) begin
            port_q   <= addr_next;
            bad_port <= ({1'b0, addr_next} >= PORTS_L);
            state    <= S_LEN;
            bit_cnt  <= CNT_W'(LEN_W - 1);
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        S_LEN: begin
          len_sh <= len_next;
          if (last_bit) begin
            word_cnt <= {1'b0, len_next};
            bit_cnt  <= CNT_W'(DATA_W - 1);
            par_acc  <= 1'b0;
            par_err  <= 1'b0;
            state    <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        S_DATA: begin
          word_sh <= word_next;
          par_acc <= par_acc ^ bus.serIn;
          if (last_bit) begin
            // A frame to a nonexistent port is consumed silently; out keeps its old word.
            if (!bad_port) begin
              out_q   <= word_next;
              valid_q <= 1'b1;
            end
            bit_cnt <= CNT_W'(DATA_W - 1);
            if (last_word) begin
              state <= (PARITY_EN != 0) ? S_PAR : S_STOP;
            end else begin
              word_cnt <= word_cnt - (LEN_W + 1)'(1);
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        S_PAR: begin
          par_err <= (bus.serIn != par_acc);
          state   <= S_STOP;
        end
        S_STOP: begin
          // Always back to IDLE, so a zero stop bit is never taken as the next start bit.
          done_q  <= 1'b1;
          error_q <= (stop_code != 2'b00);
          code_q  <= stop_code;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.out        = out_q;
  assign bus.validOut   = valid_q;
  assign bus.activePort = port_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.errCode    = code_q;
endmodule

// File: tb/tb_param_serial_demux.sv
// tb/tb_param_serial_demux.sv - randomized self-checking bench for param_serial_demux
module tb_param_serial_demux;
  localparam int DATA_W = 4;
  localparam int LEN_W  = 4;
  localparam int PORT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ser = 1'b1;

  always #5 clk = ~clk;

  param_serial_demux_if #(.PORTS(4), .DATA_W(DATA_W)) b4 ();
  param_serial_demux_if #(.PORTS(3), .DATA_W(DATA_W)) b3 ();

  assign b4.serIn = ser;
  assign b3.serIn = ser;

  param_serial_demux #(.PORTS(4), .DATA_W(DATA_W), .LEN_W(LEN_W), .PARITY_EN(1)) u_dut4 (
    .clk(clk), .rst(rst), .bus(b4)
  );
  param_serial_demux #(.PORTS(3), .DATA_W(DATA_W), .LEN_W(LEN_W), .PARITY_EN(1)) u_dut3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  int tests = 0;
  int fails = 0;
  int ecount = 0;

  int g4_w[$], g4_wt[$], g4_d[$], g4_dt[$];
  int g3_w[$], g3_wt[$], g3_d[$], g3_dt[$];
  int e4_w[$], e4_wt[$], e4_d[$], e4_dt[$];
  int e3_w[$], e3_wt[$], e3_d[$], e3_dt[$];
  int fw[$];

  // Observe both DUTs just after each edge; done records carry {busy, error, errCode}.
  always @(posedge clk) begin
    #1;
    ecount++;
    if (b4.validOut) begin g4_w.push_back(int'(b4.out)); g4_wt.push_back(ecount); end
    if (b4.done) begin g4_d.push_back(int'({b4.busy, b4.error, b4.errCode})); g4_dt.push_back(ecount); end
    if (b3.validOut) begin g3_w.push_back(int'(b3.out)); g3_wt.push_back(ecount); end
    if (b3.done) begin g3_d.push_back(int'({b3.busy, b3.error, b3.errCode})); g3_dt.push_back(ecount); end
  end

  task automatic clear_q();
    g4_w.delete(); g4_wt.delete(); g4_d.delete(); g4_dt.delete();
    g3_w.delete(); g3_wt.delete(); g3_d.delete(); g3_dt.delete();
    e4_w.delete(); e4_wt.delete(); e4_d.delete(); e4_dt.delete();
    e3_w.delete(); e3_wt.delete(); e3_d.delete(); e3_dt.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); ser = 1'b1; end
  endtask

  // Reference: error classification straight from the frame contents.
  function automatic int exp_done(input int ports, input int port, input bit par_bad, input bit stop);
    int code;
    if (!stop) code = 3;
    else if (par_bad) code = 2;
    else if (port >= ports) code = 1;
    else code = 0;
    return (code != 0) ? (4 + code) : 0;
  endfunction

  // Serialise one frame carrying the words in fw and log what each DUT must report.
  task automatic send_frame(input int port, input bit pflip, input bit stop);
    bit bits[$];
    bit xr;
    int len;
    int start;
    int w;
    len = fw.size() - 1;
    xr = 1'b0;
    bits.push_back(1'b0);
    for (int i = PORT_W - 1; i >= 0; i--) bits.push_back(port[i]);
    for (int i = LEN_W - 1; i >= 0; i--) bits.push_back(len[i]);
    for (int k = 0; k < fw.size(); k++) begin
      w = fw[k];
      for (int i = DATA_W - 1; i >= 0; i--) begin bits.push_back(w[i]); xr ^= w[i]; end
    end
    bits.push_back(xr ^ pflip);
    bits.push_back(stop);
    @(negedge clk);
    start = ecount + 1;
    for (int k = 0; k < fw.size(); k++) begin
      if (port < 4) begin e4_w.push_back(fw[k]); e4_wt.push_back(start + PORT_W + LEN_W + (k + 1) * DATA_W); end
      if (port < 3) begin e3_w.push_back(fw[k]); e3_wt.push_back(start + PORT_W + LEN_W + (k + 1) * DATA_W); end
    end
    e4_d.push_back(exp_done(4, port, pflip, stop)); e4_dt.push_back(start + bits.size() - 1);
    e3_d.push_back(exp_done(3, port, pflip, stop)); e3_dt.push_back(start + bits.size() - 1);
    for (int i = 0; i < bits.size(); i++) begin
      if (i > 0) @(negedge clk);
      ser = bits[i];
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ser = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({b4.out, b4.validOut, b4.activePort, b4.busy, b4.done, b4.error, b4.errCode} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got out=%0h v=%0b p=%0d busy=%0b done=%0b err=%0b code=%0d required all 0",
               b4.out, b4.validOut, b4.activePort, b4.busy, b4.done, b4.error, b4.errCode);
    end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    clear_q();
    fw = '{10, 6};
    send_frame(3, 1'b0, 1'b1);
    idle(3);
    tests++;
    if (b4.activePort !== 2'd3) begin fails++; $display("FAIL basic_port got %0d required 3", b4.activePort); end
    tests++;
    if (g4_w.size() != e4_w.size()) begin
      fails++; $display("FAIL basic_nwords got %0d required %0d", g4_w.size(), e4_w.size());
    end else foreach (e4_w[i]) begin
      tests++;
      if (g4_w[i] !== e4_w[i] || g4_wt[i] !== e4_wt[i]) begin
        fails++; $display("FAIL basic_word%0d got %0h@%0d required %0h@%0d", i, g4_w[i], g4_wt[i], e4_w[i], e4_wt[i]);
      end
    end
    tests++;
    if (g4_d.size() != 1 || g4_d[0] !== e4_d[0] || g4_dt[0] !== e4_dt[0]) begin
      fails++; $display("FAIL basic_done got n=%0d rec=%0h required rec=%0h@%0d", g4_d.size(), (g4_d.size() > 0) ? g4_d[0] : -1, e4_d[0], e4_dt[0]);
    end
  endtask

  task automatic test_parity();
    clear_q();
    fw = '{10, 6};
    send_frame(3, 1'b1, 1'b1);
    idle(3);
    tests++;
    if (g4_w.size() != 2 || g4_w[0] !== 10 || g4_w[1] !== 6) begin
      fails++; $display("FAIL parity_words got n=%0d required 2 words a,6", g4_w.size());
    end
    tests++;
    if (g4_d.size() != 1 || g4_d[0] !== e4_d[0] || g4_dt[0] !== e4_dt[0]) begin
      fails++; $display("FAIL parity_done got n=%0d rec=%0h required rec=%0h", g4_d.size(), (g4_d.size() > 0) ? g4_d[0] : -1, e4_d[0]);
    end
  endtask

  task automatic test_framing();
    clear_q();
    fw = '{5};
    send_frame(1, 1'b0, 1'b0);
    fw = '{9, 3};
    send_frame(2, 1'b0, 1'b1);
    idle(3);
    tests++;
    if (g4_d.size() != e4_d.size()) begin
      fails++; $display("FAIL framing_ndone got %0d required %0d", g4_d.size(), e4_d.size());
    end else foreach (e4_d[i]) begin
      tests++;
      if (g4_d[i] !== e4_d[i] || g4_dt[i] !== e4_dt[i]) begin
        fails++; $display("FAIL framing_done%0d got %0h@%0d required %0h@%0d", i, g4_d[i], g4_dt[i], e4_d[i], e4_dt[i]);
      end
    end
    tests++;
    if (g4_w.size() != e4_w.size()) begin
      fails++; $display("FAIL framing_nwords got %0d required %0d", g4_w.size(), e4_w.size());
    end else foreach (e4_w[i]) begin
      tests++;
      if (g4_w[i] !== e4_w[i] || g4_wt[i] !== e4_wt[i]) begin
        fails++; $display("FAIL framing_word%0d got %0h@%0d required %0h@%0d", i, g4_w[i], g4_wt[i], e4_w[i], e4_wt[i]);
      end
    end
  endtask

  task automatic test_bad_port();
    logic [DATA_W-1:0] prev;
    clear_q();
    prev = b3.out;
    fw = '{5};
    send_frame(3, 1'b0, 1'b1);
    idle(3);
    tests++;
    if (g3_w.size() != 0 || b3.out !== prev) begin
      fails++; $display("FAIL badport_words got n=%0d out=%0h required n=0 out=%0h", g3_w.size(), b3.out, prev);
    end
    tests++;
    if (g3_d.size() != 1 || g3_d[0] !== e3_d[0] || g3_dt[0] !== e3_dt[0]) begin
      fails++; $display("FAIL badport_done got n=%0d rec=%0h required rec=%0h", g3_d.size(), (g3_d.size() > 0) ? g3_d[0] : -1, e3_d[0]);
    end
    tests++;
    if (b3.errCode !== 2'b01 || b3.activePort !== 2'd3) begin
      fails++; $display("FAIL badport_hold got code=%0d port=%0d required code=1 port=3", b3.errCode, b3.activePort);
    end
    tests++;
    if (g4_w.size() != 1 || g4_w[0] !== 5 || g4_d.size() != 1 || g4_d[0] !== 0) begin
      fails++; $display("FAIL badport_ref4 got nw=%0d nd=%0d required nw=1 nd=1 clean", g4_w.size(), g4_d.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    fw.delete();
    for (int i = 0; i < 16; i++) fw.push_back(i);
    send_frame(0, 1'b0, 1'b1);
    fw = '{7, 8};
    send_frame(1, 1'b0, 1'b1);
    idle(3);
    tests++;
    if (g4_w.size() != e4_w.size()) begin
      fails++; $display("FAIL b2b_nwords got %0d required %0d", g4_w.size(), e4_w.size());
    end else foreach (e4_w[i]) begin
      tests++;
      if (g4_w[i] !== e4_w[i] || g4_wt[i] !== e4_wt[i]) begin
        fails++; $display("FAIL b2b_word%0d got %0h@%0d required %0h@%0d", i, g4_w[i], g4_wt[i], e4_w[i], e4_wt[i]);
      end
    end
    tests++;
    if (g4_d.size() != 2 || g4_d[0] !== e4_d[0] || g4_d[1] !== e4_d[1] || g4_dt[0] !== e4_dt[0] || g4_dt[1] !== e4_dt[1]) begin
      fails++; $display("FAIL b2b_done got n=%0d required 2 clean dones at %0d,%0d", g4_d.size(), e4_dt[0], e4_dt[1]);
    end
  endtask

  task automatic test_mid_reset();
    bit part[$];
    clear_q();
    part = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    foreach (part[i]) begin @(negedge clk); ser = part[i]; end
    @(negedge clk);
    ser = 1'b1;
    tests++;
    if (b4.busy !== 1'b1 || b4.activePort !== 2'd2) begin
      fails++; $display("FAIL midrst_pre got busy=%0b port=%0d required busy=1 port=2", b4.busy, b4.activePort);
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({b4.out, b4.validOut, b4.activePort, b4.busy, b4.done, b4.error, b4.errCode} !== '0) begin
      fails++; $display("FAIL midrst_outputs got out=%0h port=%0d busy=%0b required all 0", b4.out, b4.activePort, b4.busy);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(20);
    tests++;
    if (g4_d.size() != 0 || g4_w.size() != 0) begin
      fails++; $display("FAIL midrst_nodone got nd=%0d nw=%0d required 0 0", g4_d.size(), g4_w.size());
    end
    fw = '{12, 1, 4};
    send_frame(2, 1'b0, 1'b1);
    idle(3);
    tests++;
    if (g4_w.size() != e4_w.size()) begin
      fails++; $display("FAIL midrst_nwords got %0d required %0d", g4_w.size(), e4_w.size());
    end else foreach (e4_w[i]) begin
      tests++;
      if (g4_w[i] !== e4_w[i] || g4_wt[i] !== e4_wt[i]) begin
        fails++; $display("FAIL midrst_word%0d got %0h@%0d required %0h@%0d", i, g4_w[i], g4_wt[i], e4_w[i], e4_wt[i]);
      end
    end
    tests++;
    if (g4_d.size() != 1 || g4_d[0] !== 0 || g4_dt[0] !== e4_dt[0]) begin
      fails++; $display("FAIL midrst_done got n=%0d required one clean done at %0d", g4_d.size(), e4_dt[0]);
    end
  endtask

  task automatic test_random();
    int nw;
    clear_q();
    for (int f = 0; f < 24; f++) begin
      fw.delete();
      nw = $urandom_range(4, 1);
      for (int k = 0; k < nw; k++) fw.push_back($urandom_range(15, 0));
      send_frame($urandom_range(3, 0), ($urandom_range(3, 0) == 0), ($urandom_range(4, 0) != 0));
      idle($urandom_range(2, 0));
    end
    idle(3);
    tests++;
    if (g4_w.size() != e4_w.size() || g3_w.size() != e3_w.size()) begin
      fails++; $display("FAIL rand_nwords got %0d/%0d required %0d/%0d", g4_w.size(), g3_w.size(), e4_w.size(), e3_w.size());
    end else begin
      foreach (e4_w[i]) begin
        tests++;
        if (g4_w[i] !== e4_w[i] || g4_wt[i] !== e4_wt[i]) begin
          fails++; $display("FAIL rand4_word%0d got %0h@%0d required %0h@%0d", i, g4_w[i], g4_wt[i], e4_w[i], e4_wt[i]);
        end
      end
      foreach (e3_w[i]) begin
        tests++;
        if (g3_w[i] !== e3_w[i] || g3_wt[i] !== e3_wt[i]) begin
          fails++; $display("FAIL rand3_word%0d got %0h@%0d required %0h@%0d", i, g3_w[i], g3_wt[i], e3_w[i], e3_wt[i]);
        end
      end
    end
    tests++;
    if (g4_d.size() != e4_d.size() || g3_d.size() != e3_d.size()) begin
      fails++; $display("FAIL rand_ndone got %0d/%0d required %0d/%0d", g4_d.size(), g3_d.size(), e4_d.size(), e3_d.size());
    end else begin
      foreach (e4_d[i]) begin
        tests++;
        if (g4_d[i] !== e4_d[i] || g4_dt[i] !== e4_dt[i]) begin
          fails++; $display("FAIL rand4_done%0d got %0h@%0d required %0h@%0d", i, g4_d[i], g4_dt[i], e4_d[i], e4_dt[i]);
        end
      end
      foreach (e3_d[i]) begin
        tests++;
        if (g3_d[i] !== e3_d[i] || g3_dt[i] !== e3_dt[i]) begin
          fails++; $display("FAIL rand3_done%0d got %0h@%0d required %0h@%0d", i, g3_d[i], g3_dt[i], e3_d[i], e3_dt[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_bad_port();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
